// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and default widths for the two-requester ALU sharing controller.
package alu_share_pkg;

  localparam int BITS_DEF = 8;
  localparam int OPW_DEF  = 4;
  localparam int FLW_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, ALU and response signals of alu_share_ctrl; names are from the controller's view.
interface alu_share_ctrl_if
  import alu_share_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int OPW  = OPW_DEF,
  parameter int FLW  = FLW_DEF
);

  logic [1:0]      i_req;
  logic [OPW-1:0]  i_op0;
  logic [OPW-1:0]  i_op1;
  logic [BITS-1:0] i_argA0;
  logic [BITS-1:0] i_argB0;
  logic [BITS-1:0] i_argA1;
  logic [BITS-1:0] i_argB1;
  logic [1:0]      o_gnt;
  logic [OPW-1:0]  o_alu_op;
  logic [BITS-1:0] o_alu_argA;
  logic [BITS-1:0] o_alu_argB;
  logic            o_alu_start;
  logic [BITS-1:0] i_alu_result;
  logic [FLW-1:0]  i_alu_flags;
  logic            o_valid;
  req_idx_t        o_owner;
  logic [BITS-1:0] o_result;
  logic [FLW-1:0]  o_flags;
  logic            i_ack;
  logic            o_timeout;

  modport master (
    output i_req, i_op0, i_op1, i_argA0, i_argB0, i_argA1, i_argB1,
    output i_alu_result, i_alu_flags, i_ack,
    input  o_gnt, o_alu_op, o_alu_argA, o_alu_argB, o_alu_start,
    input  o_valid, o_owner, o_result, o_flags, o_timeout
  );

  modport slave (
    input  i_req, i_op0, i_op1, i_argA0, i_argB0, i_argA1, i_argB1,
    input  i_alu_result, i_alu_flags, i_ack,
    output o_gnt, o_alu_op, o_alu_argA, o_alu_argB, o_alu_start,
    output o_valid, o_owner, o_result, o_flags, o_timeout
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Combinational 2-way round-robin pick: on contention the requester that did not win last time wins.
module rr_arb2
  import alu_share_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_idx_t   i_last,
  output logic [1:0] o_win_oh,
  output req_idx_t   o_win_idx,
  output logic       o_any
);

  always_comb begin
    o_win_idx = 1'b0;
    if (i_req == 2'b11) begin
      o_win_idx = ~i_last;
    end else if (!i_req[0]) begin
      o_win_idx = 1'b1;
    end
  end

  assign o_any = |i_req;

  for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
    assign o_win_oh[gi] = o_any && (o_win_idx == req_idx_t'(gi));
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one fixed-latency ALU between two requesters and holds each response until acknowledged.
// Optional response timeout is enabled by defining ALU_SHARE_TIMEOUT_EN.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int OPW  = OPW_DEF,
  parameter int FLW  = FLW_DEF,
  parameter int LAT  = 2,
  parameter int TMO  = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  alu_share_ctrl_if.slave bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  if (LAT < 1 || TMO < 1) begin : g_param_chk
    $error("alu_share_ctrl: LAT and TMO must both be >= 1");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  req_idx_t        last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [BITS-1:0] arga_q, arga_d;
  logic [BITS-1:0] argb_q, argb_d;
  req_idx_t        owner_q, owner_d;
  logic            valid_q, valid_d;
  logic [BITS-1:0] result_q, result_d;
  logic [FLW-1:0]  flags_q, flags_d;

  logic [1:0]      win_oh;
  req_idx_t        win_idx;
  logic            win_any;

  rr_arb2 u_arb (
    .i_req     (bus.i_req),
    .i_last    (last_q),
    .o_win_oh  (win_oh),
    .o_win_idx (win_idx),
    .o_any     (win_any)
  );

`ifdef ALU_SHARE_TIMEOUT_EN
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TMO - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = '0;
    op_d     = op_q;
    arga_d   = arga_q;
    argb_d   = argb_q;
    owner_d  = owner_q;
    valid_d  = valid_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_SHARE_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = EXEC;
          cnt_d   = '0;
          gnt_d   = win_oh;
          owner_d = win_idx;
          last_d  = win_idx;
          op_d    = win_idx ? bus.i_op1   : bus.i_op0;
          arga_d  = win_idx ? bus.i_argA1 : bus.i_argA0;
          argb_d  = win_idx ? bus.i_argB1 : bus.i_argB0;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = bus.i_alu_result;
          flags_d  = bus.i_alu_flags;
          valid_d  = 1'b1;
          state_d  = RESP;
`ifdef ALU_SHARE_TIMEOUT_EN
          tcnt_d   = '0;
`endif
        end
      end
      RESP: begin
        if (bus.i_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
`ifdef ALU_SHARE_TIMEOUT_EN
        // Dropped response leaves last-owner as set at grant time.
        else if (tcnt_q == TCNT_LAST) begin
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= '0;
      op_q     <= '0;
      arga_q   <= '0;
      argb_q   <= '0;
      owner_q  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_alu_op    = op_q;
  assign bus.o_alu_argA  = arga_q;
  assign bus.o_alu_argB  = argb_q;
  assign bus.o_alu_start = (state_q == EXEC) && (cnt_q == '0);
  assign bus.o_valid     = valid_q;
  assign bus.o_owner     = owner_q;
  assign bus.o_result    = result_q;
  assign bus.o_flags     = flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed ops push expected grants/responses, a monitor pops and checks.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic [1:0] gnt;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } gexp_t;

  typedef struct {
    logic       owner;
    logic [7:0] result;
    logic [3:0] flags;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic auto_ack = 1'b1;
  logic man_ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int gnt_seen = 0;
  logic tmo_seen = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_acc = 1'b0;
  logic [12:0] prev_snap = '0;

  gexp_t gq[$];
  rexp_t rq[$];

  alu_share_ctrl_if #(.BITS(8), .OPW(4), .FLW(4)) bus ();

  alu_share_ctrl #(.BITS(8), .OPW(4), .FLW(4), .LAT(LAT), .TMO(15)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: op 3 = add, op 5 = xor; flags {N, Z, H, C}.
  always_comb begin
    logic [8:0] s;
    logic [4:0] h;
    s = '0;
    h = '0;
    bus.i_alu_result = '0;
    bus.i_alu_flags  = '0;
    case (bus.o_alu_op)
      4'd3: begin
        s = {1'b0, bus.o_alu_argA} + {1'b0, bus.o_alu_argB};
        h = {1'b0, bus.o_alu_argA[3:0]} + {1'b0, bus.o_alu_argB[3:0]};
        bus.i_alu_result = s[7:0];
        bus.i_alu_flags  = {s[7], s[7:0] == 8'h00, h[4], s[8]};
      end
      4'd5: begin
        bus.i_alu_result = bus.o_alu_argA ^ bus.o_alu_argB;
        bus.i_alu_flags  = {bus.i_alu_result[7], bus.i_alu_result == 8'h00, 2'b00};
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    bus.i_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.i_ack = auto_ack ? bus.o_valid : man_ack;
    end
  end

  // Monitor samples mid-low-phase, after stimulus and ack have settled.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst_n) begin
      check("start_with_gnt", 32'(bus.o_alu_start), 32'(bus.o_gnt != 2'b00));
      if (bus.o_gnt != 2'b00) begin
        gexp_t g;
        gnt_seen++;
        gnt_cyc = cyc;
        if (gq.size() == 0) begin
          check("unexpected_gnt", 32'(bus.o_gnt), 32'd0);
        end else begin
          g = gq.pop_front();
          check("gnt", 32'(bus.o_gnt), 32'(g.gnt));
          check("alu_op", 32'(bus.o_alu_op), 32'(g.op));
          check("alu_args", {16'd0, bus.o_alu_argA, bus.o_alu_argB}, {16'd0, g.a, g.b});
          $display("grant %b op=%0d A=%h B=%h at cycle %0d", bus.o_gnt, bus.o_alu_op,
                   bus.o_alu_argA, bus.o_alu_argB, cyc);
        end
      end
      if (prev_acc) check("valid_drop_after_ack", 32'(bus.o_valid), 32'd0);
      if (bus.o_valid && !prev_valid) begin
        rexp_t r;
        if (rq.size() == 0) begin
          check("unexpected_valid", 32'(bus.o_valid), 32'd0);
        end else begin
          r = rq.pop_front();
          check("owner", 32'(bus.o_owner), 32'(r.owner));
          check("result", 32'(bus.o_result), 32'(r.result));
          check("flags", 32'(bus.o_flags), 32'(r.flags));
          check("latency", 32'(cyc - gnt_cyc), 32'(LAT));
          $display("response owner=%0d result=%h flags=%b at cycle %0d", bus.o_owner,
                   bus.o_result, bus.o_flags, cyc);
        end
      end
      if (bus.o_valid && prev_valid) begin
        check("resp_stable", 32'({bus.o_owner, bus.o_result, bus.o_flags}), 32'(prev_snap));
        check("no_gnt_in_resp", 32'(bus.o_gnt), 32'd0);
      end
      if (bus.o_timeout) tmo_seen = 1'b1;
      prev_valid = bus.o_valid;
      prev_acc   = bus.o_valid && bus.i_ack;
      prev_snap  = {bus.o_owner, bus.o_result, bus.o_flags};
    end else begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
    end
  end

  task automatic wait_gnt(input int n);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #3;
      if (gnt_seen >= n) break;
    end
    if (k == 100) check("wait_gnt_bound", 32'(gnt_seen), 32'(n));
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #3;
      if (bus.o_valid) break;
    end
    if (k == 100) check("wait_valid_bound", 32'(bus.o_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #3;
      if (rq.size() == 0 && !bus.o_valid) break;
    end
    if (k == 100) check("wait_idle_bound", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    bus.i_req   = 2'b11;
    bus.i_op0   = 4'd3;  bus.i_argA0 = 8'h80; bus.i_argB0 = 8'h80;
    bus.i_op1   = 4'd5;  bus.i_argA1 = 8'hA5; bus.i_argB1 = 8'h5A;

    // Reset held with both requests high: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      check("reset_ctrl", {19'd0, bus.o_gnt, bus.o_alu_start, bus.o_valid, bus.o_owner,
                           bus.o_timeout, bus.o_alu_op, 4'd0},
            32'd0);
      check("reset_data", {4'd0, bus.o_alu_argA, bus.o_alu_argB, bus.o_result, bus.o_flags},
            32'd0);
    end

    // Contention, immediate ack: 0,1,0,1.
    for (int i = 0; i < 2; i++) begin
      gq.push_back('{2'b01, 4'd3, 8'h80, 8'h80});
      rq.push_back('{1'b0, 8'h00, 4'b0101});
      gq.push_back('{2'b10, 4'd5, 8'hA5, 8'h5A});
      rq.push_back('{1'b1, 8'hFF, 4'b1000});
    end
    rst_n = 1'b1;
    wait_gnt(4);
    bus.i_req = 2'b00;
    wait_idle();

    // Single op from requester 0.
    bus.i_op0 = 4'd3; bus.i_argA0 = 8'h0F; bus.i_argB0 = 8'h01;
    gq.push_back('{2'b01, 4'd3, 8'h0F, 8'h01});
    rq.push_back('{1'b0, 8'h10, 4'b0010});
    bus.i_req = 2'b01;
    wait_gnt(5);
    bus.i_req = 2'b00;
    wait_idle();

    // Back-pressure: ack withheld 10 cycles while requester 1 keeps asking.
    auto_ack = 1'b0;
    bus.i_op1 = 4'd3; bus.i_argA1 = 8'hFF; bus.i_argB1 = 8'h02;
    gq.push_back('{2'b10, 4'd3, 8'hFF, 8'h02});
    rq.push_back('{1'b1, 8'h01, 4'b0011});
    bus.i_req = 2'b10;
    wait_gnt(6);
    wait_valid();
    repeat (10) @(negedge clk);
    #3;
    check("bp_valid_held", 32'(bus.o_valid), 32'd1);
    check("bp_no_new_gnt", 32'(gnt_seen), 32'd6);
    bus.i_req = 2'b00;
    man_ack = 1'b1;
    wait_idle();
    man_ack = 1'b0;
    auto_ack = 1'b1;

    // Reset during the second EXEC cycle drops the op.
    bus.i_op0 = 4'd3; bus.i_argA0 = 8'h01; bus.i_argB0 = 8'h01;
    gq.push_back('{2'b01, 4'd3, 8'h01, 8'h01});
    bus.i_req = 2'b01;
    wait_gnt(7);
    bus.i_req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("no_valid_after_rst", 32'(bus.o_valid), 32'd0);
    end

    // last-owner back to 1, so contention goes to requester 0.
    bus.i_op0 = 4'd5; bus.i_argA0 = 8'h3C; bus.i_argB0 = 8'h0F;
    gq.push_back('{2'b01, 4'd5, 8'h3C, 8'h0F});
    rq.push_back('{1'b0, 8'h33, 4'b0000});
    bus.i_req = 2'b11;
    wait_gnt(8);
    bus.i_req = 2'b00;
    wait_idle();
    repeat (3) @(negedge clk);
    #3;

    check("gnt_queue_empty", 32'(gq.size()), 32'd0);
    check("rsp_queue_empty", 32'(rq.size()), 32'd0);
`ifndef ALU_SHARE_TIMEOUT_EN
    check("no_timeout", 32'(tmo_seen), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Controller that shares one ALU datapath (with its flag logic) between two requesters. It arbitrates round-robin and latches the winner's opcode and operands. It then drives the ALU for a fixed latency, captures result and flags, and holds them until the owner acknowledges. It sits between the requesting front-ends and the ALU plus flag units.

Parameters:
BITS, 8, operand/result width
OPW, 4, opcode width
FLW, 4, flag vector width (opaque bundle from flag units)
LAT, 2, ALU latency in cycles, must be >= 1
TMO, 15, response timeout in cycles (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_req  in  2  request per requester (bit n = requester n)
i_op0, i_op1  in  OPW  opcode per requester
i_argA0, i_argB0, i_argA1, i_argB1  in  BITS  operands per requester
o_gnt  out  2  one-hot grant pulse
o_alu_op  out  OPW  opcode to ALU
o_alu_argA, o_alu_argB  out  BITS  operands to ALU
o_alu_start  out  1  one-cycle start pulse to ALU
i_alu_result  in  BITS  ALU result
i_alu_flags  in  FLW  ALU flags
o_valid  out  1  response valid
o_owner  out  1  requester index owning response
o_result  out  BITS  captured result
o_flags  out  FLW  captured flags
i_ack  in  1  response acknowledge
o_timeout  out  1  one-cycle timeout pulse

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is synchronous and active-low.
- Reset values:
  - state IDLE; all outputs 0.
  - last-owner register = 1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE, any i_req set:
  - At the edge, pick the winner:
    - only one request: that requester;
    - both: the requester != last-owner.
  - Latch winner op/args into o_alu_op/argA/argB; set o_owner and last-owner.
  - o_gnt[winner]=1 for exactly the next cycle; go to EXEC with counter=0.
- IDLE, no request: outputs hold; o_alu_* hold last values.
- EXEC:
  - o_alu_start=1 in the first EXEC cycle only.
  - Counter increments each cycle.
  - Operands stay stable for the whole EXEC.
- EXEC, counter==LAT-1:
  - At the edge, capture i_alu_result into o_result and i_alu_flags into o_flags.
  - Set o_valid=1 and go to RESP.
- RESP:
  - o_valid, o_result, o_flags, o_owner are held stable.
  - When o_valid & i_ack at an edge: o_valid=0 next cycle and go to IDLE.
- i_ack outside RESP is ignored.
- Requests are level-held. A requester deasserts or changes i_req after seeing its o_gnt. i_req during EXEC/RESP is ignored and does not alter priority.
- Minimum turnaround is LAT+2 cycles per operation (ack in the first RESP cycle). No new grant occurs in the ack cycle.
- Simultaneous requests repeatedly held high alternate grants 0,1,0,1.
- Reset mid-operation drops the in-flight op with no response. last-owner returns to 1.
- Width rules: result and flags are captured verbatim, with no extension or truncation.

Optional Feature:
ALU_SHARE_TIMEOUT_EN
- Defined:
  - An RESP-cycle counter starts at 0 on RESP entry.
  - If TMO cycles pass without i_ack: o_timeout pulses for 1 cycle, o_valid clears, state returns to IDLE.
  - The response is discarded and last-owner is unchanged.
- Undefined: RESP waits indefinitely; o_timeout is tied to 0. The port is present in both builds.

Decomposition:
- Package alu_share_pkg:
  - state enum (IDLE, EXEC, RESP);
  - default width constants for BITS, OPW, FLW;
  - requester index type.
- One natural sub-module: rr_arb2. It is a combinational 2-way round-robin pick from i_req and last-owner, producing a one-hot winner and winner index.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_req=2'b11 -> all outputs 0, no grant; after release, first grant is o_gnt=2'b01.
- Single op, LAT=2: i_req=01, op0=3, A0=8'h0F, B0=8'h01, ALU returns result 8'h10, flags 4'b0010:
  - o_gnt=01 at T+1, o_alu_start at T+1;
  - o_valid at T+3 with o_result=8'h10, o_flags=4'b0010, o_owner=0;
  - i_ack at T+3 -> o_valid=0 at T+4.
- Contention: i_req=11 held for 4 ops, ack immediately -> grants 01,10,01,10; o_owner alternates 0,1,0,1.
- Back-pressure: withhold i_ack for 10 cycles -> o_valid, o_result, o_flags stable throughout; no new o_gnt despite i_req=10.
- Reset mid-EXEC: assert i_rst_n=0 during the 2nd EXEC cycle -> no o_valid ever for that op; next grant goes to requester 0.
- With ALU_SHARE_TIMEOUT_EN, TMO=15: no ack -> o_timeout pulses after 15 RESP cycles, o_valid=0 the following cycle, new request is granted afterward.
